// File: rtl/rv32i_mem_pkg.sv
// Shared types and funct3 encodings for the RV32I data-memory responder.
package rv32i_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StResp
  } dm_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and shift/extension for loads within one 32-bit word.
module mem_lane_align
  import rv32i_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] st_word,
  output logic [31:0] ld_word,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    byte_en  = 4'b0000;
    st_word  = wr_data;
    ld_word  = '0;
    misalign = 1'b0;
    shifted  = rd_word >> {addr_lo, 3'b000};

    // funct3[1:0] gives the access size for both signed and unsigned forms
    unique case (funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << addr_lo;
        st_word = {4{wr_data[7:0]}};
      end
      2'b01: begin
        byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_word  = {2{wr_data[15:0]}};
        misalign = addr_lo[0];
      end
      2'b10: begin
        byte_en  = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: begin
        byte_en = 4'b0000;
      end
    endcase

    unique case (funct3)
      F3_B:    ld_word = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_word = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    ld_word = shifted;
      F3_BU:   ld_word = {24'h0, shifted[7:0]};
      F3_HU:   ld_word = {16'h0, shifted[15:0]};
      default: ld_word = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Slave end of the RV32I load/store interface: one request at a time, fixed wait states,
// single-cycle response with error flagging.
module data_mem_responder
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned DepthWords = 256,
  parameter int unsigned WaitCycles = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic        rsp_valid,
  output logic [31:0] rd_data,
  output logic        err
);

  localparam int unsigned IdxW = (DepthWords > 1) ? $clog2(DepthWords) : 1;
  localparam int unsigned CntW = (WaitCycles > 1) ? $clog2(WaitCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (WaitCycles == 0) ? '0 : CntW'(WaitCycles - 1);

  dm_state_t       state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  logic        req_we_q;
  logic [2:0]  req_funct3_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wr_data_q;

  logic        rsp_valid_q;
  logic [31:0] rd_data_q;
  logic        err_q;

  logic [31:0] mem [DepthWords];

  logic            accept;
  logic [IdxW-1:0] word_idx;
  logic [31:0]     rd_word;
  logic [3:0]      byte_en;
  logic [31:0]     st_word;
  logic [31:0]     ld_word;
  logic            misalign;
  logic            bad_funct3;
  logic            out_of_range;
  logic            acc_err;
  logic            do_access;

  assign req_ready = (state_q == StIdle) & ~rst;
  assign accept    = req_valid & req_ready;

  assign word_idx = req_addr_q[IdxW+1:2];
  assign rd_word  = mem[word_idx];

  mem_lane_align u_align (
    .funct3   (req_funct3_q),
    .addr_lo  (req_addr_q[1:0]),
    .wr_data  (req_wr_data_q),
    .rd_word  (rd_word),
    .byte_en  (byte_en),
    .st_word  (st_word),
    .ld_word  (ld_word),
    .misalign (misalign)
  );

  // Stores only exist in the B/H/W encodings; 011/110/111 are illegal for both directions
  assign bad_funct3   = (req_funct3_q == 3'b011) || (req_funct3_q[2:1] == 2'b11) ||
                        (req_we_q && req_funct3_q[2]);
  assign out_of_range = req_addr_q[31:2] >= 30'(DepthWords);
  assign acc_err      = misalign | bad_funct3 | out_of_range;
  assign do_access    = (state_q == StAccess);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = (WaitCycles == 0) ? StAccess : StWait;
          wait_cnt_d = '0;
        end
      end
      StWait: begin
        if (wait_cnt_q == CntLast) begin
          state_d = StAccess;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      req_we_q      <= 1'b0;
      req_funct3_q  <= '0;
      req_addr_q    <= '0;
      req_wr_data_q <= '0;
      rsp_valid_q   <= 1'b0;
      rd_data_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (accept) begin
        req_we_q      <= we;
        req_funct3_q  <= funct3;
        req_addr_q    <= addr;
        req_wr_data_q <= wr_data;
      end
      rsp_valid_q <= do_access;
      err_q       <= do_access & acc_err;
      rd_data_q   <= (do_access && !req_we_q && !acc_err) ? ld_word : '0;
    end
  end

  // Array is deliberately not reset; a reset on the access edge drops the store
  always_ff @(posedge clk) begin
    if (!rst && do_access && req_we_q && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= st_word[8*b +: 8];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rd_data   = rd_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed loads/stores, errors, reset abort, throughput.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic        rsp_valid;
  logic [31:0] rd_data;
  logic        err;

  logic        tp_valid = 1'b0;
  logic        ready0, rsp0, err0;
  logic        ready3, rsp3, err3;
  logic [31:0] rd0, rd3;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DepthWords(256), .WaitCycles(1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .we        (we),
    .funct3    (funct3),
    .addr      (addr),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rd_data   (rd_data),
    .err       (err)
  );

  data_mem_responder #(.DepthWords(256), .WaitCycles(0)) u_dut_w0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (tp_valid),
    .req_ready (ready0),
    .we        (1'b0),
    .funct3    (3'b010),
    .addr      (32'h0),
    .wr_data   (32'h0),
    .rsp_valid (rsp0),
    .rd_data   (rd0),
    .err       (err0)
  );

  data_mem_responder #(.DepthWords(256), .WaitCycles(3)) u_dut_w3 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (tp_valid),
    .req_ready (ready3),
    .we        (1'b0),
    .funct3    (3'b010),
    .addr      (32'h0),
    .wr_data   (32'h0),
    .rsp_valid (rsp3),
    .rd_data   (rd3),
    .err       (err3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_err", {31'h0, err}, {31'h0, e.err});
        check("rsp_data", rd_data, e.data);
        check("rsp_latency", cyc, e.due);
      end
    end
  end

  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit push, input logic e_err,
                       input logic [31:0] e_data);
    int guard;
    exp_t e;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1;
    we        = w;
    funct3    = f3;
    addr      = a;
    wr_data   = d;
    @(posedge clk);
    #1;
    if (push) begin
      e.err  = e_err;
      e.data = e_data;
      e.due  = cyc + 2;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input logic e_err, input logic [31:0] e_data);
    issue(w, f3, a, d, 1'b1, e_err, e_data);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0[$];
    int acc3[$];
    int nrsp0, nrsp3;

    repeat (2) @(negedge clk);
    check("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_err", {31'h0, err}, 32'd0);
    check("ready_in_reset", {31'h0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", {31'h0, req_ready}, 32'd1);
    @(negedge clk);

    // Word store, loads with extension
    txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    txn(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDE);
    txn(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h000000DE);
    txn(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFFDEAD);
    txn(1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000BEEF);

    // Partial stores
    txn(1'b1, 3'b000, 32'h11, 32'h12345677, 1'b0, 32'h0);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEAD77EF);
    txn(1'b1, 3'b001, 32'h12, 32'h0000CAFE, 1'b0, 32'h0);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hCAFE77EF);

    // Errors leave memory untouched
    txn(1'b1, 3'b010, 32'h0, 32'h11111111, 1'b0, 32'h0);
    txn(1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0);
    txn(1'b1, 3'b001, 32'h11, 32'h0000ABCD, 1'b1, 32'h0);
    txn(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0);
    txn(1'b1, 3'b100, 32'h10, 32'h99999999, 1'b1, 32'h0);
    txn(1'b1, 3'b000, 32'h400, 32'h000000AA, 1'b1, 32'h0);
    txn(1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 32'h0);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hCAFE77EF);
    txn(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h11111111);

    // Reset during WAIT aborts the second store with no response
    txn(1'b1, 3'b010, 32'h20, 32'h00000001, 1'b0, 32'h0);
    issue(1'b1, 3'b010, 32'h20, 32'h00000055, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    check("ready_during_rst", {31'h0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    txn(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h00000001);

    // Throughput with valid held high on the 0- and 3-wait instances
    nrsp0 = 0;
    nrsp3 = 0;
    tp_valid = 1'b1;
    for (int c = 0; c < 36; c++) begin
      if (ready0 === 1'b1) acc0.push_back(c);
      if (ready3 === 1'b1) acc3.push_back(c);
      if (rsp0 === 1'b1) nrsp0++;
      if (rsp3 === 1'b1) nrsp3++;
      @(negedge clk);
    end
    tp_valid = 1'b0;
    check("tp_accepts_w0", acc0.size(), 32'd12);
    check("tp_accepts_w3", acc3.size(), 32'd6);
    check("tp_rsps_w0", nrsp0, 32'd12);
    check("tp_rsps_w3", nrsp3, 32'd6);
    for (int i = 1; i < acc0.size(); i++) check("tp_gap_w0", acc0[i] - acc0[i-1], 32'd3);
    for (int i = 1; i < acc3.size(); i++) check("tp_gap_w3", acc3[i] - acc3[i-1], 32'd6);

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
